// File: rtl/color_stabilizer_if.sv
// rtl/color_stabilizer_if.sv - sensor sample and stable-color report signals
// master drives the motor/sensor side, slave is the stabilizer.
interface color_stabilizer_if;
   logic       motors_done;
   logic       raw_valid;
   logic [2:0] corner_raw;
   logic [2:0] edge_raw;
   logic [2:0] corner_color_sensor;
   logic [2:0] edge_color_sensor;
   logic       color_sensor_stable;
   logic       sensor_error;
   logic       busy;

   modport master (
      output motors_done, raw_valid, corner_raw, edge_raw,
      input  corner_color_sensor, edge_color_sensor, color_sensor_stable, sensor_error, busy
   );

   modport slave (
      input  motors_done, raw_valid, corner_raw, edge_raw,
      output corner_color_sensor, edge_color_sensor, color_sensor_stable, sensor_error, busy
   );
endinterface

// File: rtl/color_stabilizer.sv
// rtl/color_stabilizer.sv - debounces corner/edge color sensors after each motor move
// Waits a settle time, then reports once a pair has been seen STABLE_COUNT times in a row.
module color_stabilizer #(
   parameter int STABLE_COUNT   = 16,
   parameter int SETTLE_CYCLES  = 1000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                clock,
   input  logic                reset_n,
   color_stabilizer_if.slave   bus
);
   localparam int MW = $clog2(STABLE_COUNT) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [MW-1:0] MATCH_DONE  = MW'(STABLE_COUNT);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [MW-1:0] match_q, match_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0]    cand_corner_q, cand_corner_d;
   logic [2:0]    cand_edge_q, cand_edge_d;
   logic [2:0]    corner_q, corner_d;
   logic [2:0]    edge_q, edge_d;
   logic          err_q, err_d;

   logic          codes_ok;
   logic          same_pair;
   logic [MW-1:0] match_inc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         settle_q      <= '0;
         match_q       <= '0;
         tmo_q         <= '0;
         cand_corner_q <= '0;
         cand_edge_q   <= '0;
         corner_q      <= '0;
         edge_q        <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         settle_q      <= settle_d;
         match_q       <= match_d;
         tmo_q         <= tmo_d;
         cand_corner_q <= cand_corner_d;
         cand_edge_q   <= cand_edge_d;
         corner_q      <= corner_d;
         edge_q        <= edge_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      settle_d      = settle_q;
      match_d       = match_q;
      tmo_d         = tmo_q;
      cand_corner_d = cand_corner_q;
      cand_edge_d   = cand_edge_q;
      corner_d      = corner_q;
      edge_d        = edge_q;
      err_d         = 1'b0;

      codes_ok  = bus.raw_valid && (bus.corner_raw <= 3'd5) && (bus.edge_raw <= 3'd5);
      same_pair = (match_q != '0) && (bus.corner_raw == cand_corner_q) &&
                  (bus.edge_raw == cand_edge_q);
      match_inc = same_pair ? match_q + MW'(1) : MW'(1);

      case (state_q)
         IDLE: begin
            if (bus.motors_done) begin
               settle_d = SETTLE_LOAD;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (bus.motors_done) begin
               settle_d = SETTLE_LOAD;
               match_d  = '0;
            end else if (settle_q == '0) begin
               state_d = SAMPLE;
               match_d = '0;
               tmo_d   = '0;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         SAMPLE: begin
            // A new move always wins; a qualifying sample beats the timeout.
            if (bus.motors_done) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
               match_d  = '0;
               tmo_d    = '0;
            end else if (codes_ok && (match_inc == MATCH_DONE)) begin
               state_d       = REPORT;
               corner_d      = bus.corner_raw;
               edge_d        = bus.edge_raw;
               cand_corner_d = bus.corner_raw;
               cand_edge_d   = bus.edge_raw;
               match_d       = '0;
               tmo_d         = '0;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               match_d = '0;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (codes_ok) begin
                  cand_corner_d = bus.corner_raw;
                  cand_edge_d   = bus.edge_raw;
                  match_d       = match_inc;
               end else if (bus.raw_valid) begin
                  match_d = '0;
               end
            end
         end
         REPORT: begin
            if (bus.motors_done) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
               match_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.corner_color_sensor = corner_q;
   assign bus.edge_color_sensor   = edge_q;
   assign bus.color_sensor_stable = (state_q == REPORT);
   assign bus.sensor_error        = err_q;
   assign bus.busy                = (state_q != IDLE);
endmodule

// File: tb/tb_color_stabilizer.sv
// tb/tb_color_stabilizer.sv - self-checking bench for color_stabilizer
// Per-cycle stimulus tables are scored against an event-level model of the sampling rules.
module tb_color_stabilizer;
   localparam int SC   = 4;
   localparam int ST   = 3;
   localparam int TO   = 20;
   localparam int NMAX = 128;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   color_stabilizer_if bus();

   color_stabilizer #(
      .STABLE_COUNT(SC),
      .SETTLE_CYCLES(ST),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   int total = 0;
   int bad = 0;

   logic       sv [NMAX];
   logic [2:0] sc [NMAX];
   logic [2:0] se [NMAX];
   logic       smd[NMAX];
   logic       err_at[NMAX];
   int         rep_t;
   logic [2:0] exp_c = 3'd0, exp_e = 3'd0, new_c, new_e;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_stim();
      for (int i = 0; i < NMAX; i++) begin
         sv[i] = 1'b0; sc[i] = 3'd0; se[i] = 3'd0; smd[i] = 1'b0;
      end
   endtask

   task automatic put(input int t, input logic [2:0] c, input logic [2:0] e);
      sv[t] = 1'b1; sc[t] = c; se[t] = e;
   endtask

   // t=0 is the first cycle after motors_done is taken; a result of cycle t shows at t+1.
   task automatic model(input int n);
      int settle_end, run, tmo, nr;
      logic ok;
      logic [2:0] cc, ce;
      settle_end = ST; run = 0; tmo = 0; cc = 3'd0; ce = 3'd0;
      rep_t = -1;
      for (int i = 0; i < NMAX; i++) err_at[i] = 1'b0;
      for (int t = 0; t < n; t++) begin
         if (smd[t]) begin
            settle_end = t + 1 + ST; run = 0; tmo = 0;
            continue;
         end
         if (t < settle_end) continue;
         ok = sv[t] && (sc[t] < 6) && (se[t] < 6);
         nr = (run > 0 && sc[t] == cc && se[t] == ce) ? run + 1 : 1;
         if (ok && nr == SC) begin
            rep_t = t + 1; new_c = sc[t]; new_e = se[t];
            break;
         end
         if (tmo == TO - 1) begin
            if (t + 1 < NMAX) err_at[t + 1] = 1'b1;
            run = 0; tmo = 0;
            continue;
         end
         tmo++;
         if (ok) begin
            run = nr; cc = sc[t]; ce = se[t];
         end else if (sv[t]) begin
            run = 0;
         end
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic run_scn(input string name, input int n);
      int last;
      logic [2:0] ec, ee;
      model(n);
      bus.motors_done = 1'b1;
      tick();
      bus.motors_done = 1'b0;
      last = (rep_t >= 0) ? rep_t + 1 : n - 1;
      for (int t = 0; t <= last; t++) begin
         bus.raw_valid   = (t < n) ? sv[t] : 1'b0;
         bus.corner_raw  = (t < n) ? sc[t] : 3'd0;
         bus.edge_raw    = (t < n) ? se[t] : 3'd0;
         bus.motors_done = (t < n && (rep_t < 0 || t < rep_t)) ? smd[t] : 1'b0;
         ec = (rep_t >= 0 && t >= rep_t) ? new_c : exp_c;
         ee = (rep_t >= 0 && t >= rep_t) ? new_e : exp_e;
         check_val($sformatf("%s.stable@%0d", name, t), 32'(bus.color_sensor_stable), 32'(t == rep_t));
         check_val($sformatf("%s.error@%0d", name, t), 32'(bus.sensor_error),
                   32'((t < n) ? err_at[t] : 1'b0));
         check_val($sformatf("%s.busy@%0d", name, t), 32'(bus.busy), 32'(rep_t < 0 || t <= rep_t));
         check_val($sformatf("%s.corner@%0d", name, t), 32'(bus.corner_color_sensor), 32'(ec));
         check_val($sformatf("%s.edge@%0d", name, t), 32'(bus.edge_color_sensor), 32'(ee));
         tick();
      end
      bus.raw_valid = 1'b0; bus.motors_done = 1'b0;
      if (rep_t >= 0) begin
         exp_c = new_c; exp_e = new_e;
      end else begin
         pulse_reset();
         exp_c = 3'd0; exp_e = 3'd0;
      end
   endtask

   task automatic reset_mid_sample();
      bus.motors_done = 1'b1;
      tick();
      bus.motors_done = 1'b0;
      repeat (ST) tick();
      bus.raw_valid = 1'b1; bus.corner_raw = 3'd5; bus.edge_raw = 3'd2;
      repeat (3) tick();
      // Fourth matching sample is on the bus when reset hits.
      reset_n = 1'b0;
      #1;
      check_val("rst.corner", 32'(bus.corner_color_sensor), 32'd0);
      check_val("rst.edge", 32'(bus.edge_color_sensor), 32'd0);
      check_val("rst.busy", 32'(bus.busy), 32'd0);
      check_val("rst.stable", 32'(bus.color_sensor_stable), 32'd0);
      tick();
      check_val("rst.stable_held", 32'(bus.color_sensor_stable), 32'd0);
      reset_n = 1'b1;
      tick();
      check_val("rst.idle_busy", 32'(bus.busy), 32'd0);
      check_val("rst.idle_stable", 32'(bus.color_sensor_stable), 32'd0);
      check_val("rst.idle_error", 32'(bus.sensor_error), 32'd0);
      bus.raw_valid = 1'b0;
      exp_c = 3'd0; exp_e = 3'd0;
   endtask

   initial begin
      bus.motors_done = 1'b0;
      bus.raw_valid   = 1'b0;
      bus.corner_raw  = 3'd0;
      bus.edge_raw    = 3'd0;
      #12;
      check_val("reset.corner", 32'(bus.corner_color_sensor), 32'd0);
      check_val("reset.edge", 32'(bus.edge_color_sensor), 32'd0);
      check_val("reset.stable", 32'(bus.color_sensor_stable), 32'd0);
      check_val("reset.error", 32'(bus.sensor_error), 32'd0);
      check_val("reset.busy", 32'(bus.busy), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      tick();

      clear_stim();
      for (int t = 0; t < 12; t++) put(t, 3'd2, 3'd4);
      run_scn("basic", 12);

      clear_stim();
      put(3, 3'd1, 3'd1); put(4, 3'd1, 3'd1);
      for (int t = 5; t < 9; t++) put(t, 3'd3, 3'd1);
      run_scn("switch", 14);

      reset_mid_sample();

      clear_stim();
      for (int t = 3; t < 6; t++) put(t, 3'd0, 3'd0);
      put(6, 3'd7, 3'd0);
      for (int t = 7; t < 11; t++) put(t, 3'd0, 3'd0);
      run_scn("invalid", 16);

      clear_stim();
      run_scn("timeout", 70);

      clear_stim();
      for (int t = 19; t < 23; t++) put(t, 3'd1, 3'd2);
      run_scn("tmo_tie", 30);

      clear_stim();
      for (int t = 3; t < 20; t++) put(t, 3'd5, 3'd2);
      smd[6] = 1'b1;
      run_scn("restart", 20);

      for (int r = 0; r < 8; r++) begin
         logic [2:0] pc, pe;
         clear_stim();
         pc = 3'($urandom_range(0, 7)); pe = 3'($urandom_range(0, 5));
         for (int t = 0; t < 90; t++) begin
            if ($urandom_range(0, 3) != 0) begin
               if ($urandom_range(0, 3) == 0) begin
                  pc = 3'($urandom_range(0, 7)); pe = 3'($urandom_range(0, 7));
               end
               put(t, pc, pe);
            end
            smd[t] = ($urandom_range(0, 39) == 0);
         end
         run_scn($sformatf("rand%0d", r), 90);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
